// File: rtl/md_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package md_pkg;

  // Operation encodings as presented on the op input.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CALC  = 2'b01,
    FIXUP = 2'b10,
    DONE  = 2'b11
  } md_state_e;

  // Quotient returned on divide-by-zero. The top slices off the low WIDTH bits.
  localparam logic [63:0] DIV0_QUOT = '1;

  // MULT and DIV are the signed operations; their op[0] bit is clear.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // op[1] separates the divide pair from the multiply pair.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the multi-cycle datapath.
//
// Multiply: the accumulator holds {partial_hi, multiplier_remaining}. The
// multiplicand is added into the upper half when the multiplier LSB is set,
// then the whole accumulator shifts right by one bit. The carry out of the add
// becomes the new top bit.
//
// Divide: the accumulator holds {partial_remainder, dividend_remaining /
// quotient_so_far}. The pair shifts left by one bit and the divisor is trial
// subtracted from the upper part. A non-negative result is kept and shifts a 1
// into the quotient. Otherwise the shifted remainder is kept and a 0 is shifted
// in. The remainder is always below the divisor, so a one-bit widening of the
// trial difference is enough to read its sign.
module md_iter_step
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Select the shift-add or restoring shift-subtract step.
  always_comb begin
    acc_o  = acc_i;
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    if (is_div_i) begin
      rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
      trial  = rem_sh - {1'b0, opnd_i};
      if (!trial[WIDTH]) begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
//
// Handshake: start is taken only in IDLE or DONE. busy is high through CALC
// and FIXUP. done pulses for one cycle in DONE, which is also the cycle in
// which the new HI/LO values first appear. MTHI/MTLO writes (we_hi/we_lo) are
// honoured only when the unit is not busy. A write and a start on the same
// edge both take effect, and the later result overwrites HI/LO.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  md_op_e             op_q, op_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Signed operations run on magnitudes. The signs are restored in FIXUP.
  assign signed_op = is_signed_op(op);
  assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

  assign busy = (state_q == CALC) || (state_q == FIXUP);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  md_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(is_div_op(op_q)),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc)
  );

  // Sequencer next-state: launch, iterate WIDTH times, fix up, report.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    a_raw_d   = a_raw_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = md_op_e'(op);
          neg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          rem_neg_d = signed_op & a[WIDTH-1];
          div0_d    = (b == '0);
          a_raw_d   = a;
          if (is_div_op(op)) begin
            acc_d  = {{WIDTH{1'b0}}, a_abs};
            opnd_d = b_abs;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_abs};
            opnd_d = a_abs;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIXUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIXUP: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Final result: apply the recorded signs, or the fixed divide-by-zero answer.
  always_comb begin
    prod_neg = -acc_q;
    res_hi   = acc_q[2*WIDTH-1:WIDTH];
    res_lo   = acc_q[WIDTH-1:0];
    if (is_div_op(op_q)) begin
      if (div0_q) begin
        res_lo = DIV0_QUOT[WIDTH-1:0];
        res_hi = a_raw_q;
      end else begin
        if (neg_q) begin
          res_lo = -acc_q[WIDTH-1:0];
        end
        if (rem_neg_q) begin
          res_hi = -acc_q[2*WIDTH-1:WIDTH];
        end
      end
    end else if (neg_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  // HI/LO update: the result when leaving FIXUP, otherwise MTHI/MTLO when idle.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FIXUP) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if (!busy) begin
      if (we_hi) begin
        hi_d = wd;
      end
      if (we_lo) begin
        lo_d = wd;
      end
    end
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      a_raw_q   <= a_raw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic vectors, latency, handshake and
// MTHI/MTLO interaction, and reset in the middle of an operation.
module tb_mul_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int n_cyc;
  int n_busy_low;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mul_div_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .we_hi(we_hi),
    .we_lo(we_lo),
    .wd   (wd),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  // Clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for exactly one rising edge. On return the bench is at the
  // falling edge of cycle 1.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called at the falling edge of cycle 1. Returns at the falling edge where
  // done is seen, together with that cycle number and the count of earlier
  // cycles in which busy was low. The wait is bounded.
  task automatic wait_done(output int cyc, output int busy_low);
    cyc      = 1;
    busy_low = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    wd    = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    reset = 1'b1;

    // MULTU: largest unsigned operands, plus latency and busy window.
    launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n_cyc, n_busy_low);
    check("multu_max_latency", n_cyc, 32'd34);
    check("multu_max_busy_low", n_busy_low, 32'd0);
    check("multu_max_hi", hi, 32'hFFFF_FFFE);
    check("multu_max_lo", lo, 32'h0000_0001);
    @(negedge clock);
    check("multu_max_done_pulse", {31'd0, done}, 32'd0);

    // MULT -3 * 5 = -15.
    launch(MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(n_cyc, n_busy_low);
    check("mult_neg_done", {31'd0, done}, 32'd1);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);

    // DIV -7 / 2 = -3 remainder -1.
    launch(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n_cyc, n_busy_low);
    check("div_neg_done", {31'd0, done}, 32'd1);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // DIVU 100 / 7 = 14 remainder 2.
    launch(DIVU, 32'd100, 32'd7);
    wait_done(n_cyc, n_busy_low);
    check("divu_done", {31'd0, done}, 32'd1);
    check("divu_lo", lo, 32'h0000_000E);
    check("divu_hi", hi, 32'h0000_0002);

    // DIV signed overflow wraps.
    launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n_cyc, n_busy_low);
    check("div_ovf_done", {31'd0, done}, 32'd1);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // DIVU by zero: full latency, all-ones quotient, dividend as remainder.
    launch(DIVU, 32'h1234_5678, 32'd0);
    wait_done(n_cyc, n_busy_low);
    check("div0_latency", n_cyc, 32'd34);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);

    // Signed DIV by zero returns the raw dividend, not a sign-adjusted one.
    launch(DIV, 32'hFFFF_FFF0, 32'd0);
    wait_done(n_cyc, n_busy_low);
    check("sdiv0_lo", lo, 32'hFFFF_FFFF);
    check("sdiv0_hi", hi, 32'hFFFF_FFF0);

    // While busy, start and we_hi are both ignored.
    launch(MULTU, 32'd5, 32'd6);
    repeat (4) @(negedge clock);
    start = 1'b1;
    op    = MULTU;
    a     = 32'd2;
    b     = 32'd2;
    we_hi = 1'b1;
    wd    = 32'hDEAD_BEEF;
    @(negedge clock);
    start = 1'b0;
    we_hi = 1'b0;
    check("busy_mthi_ignored", hi, 32'hFFFF_FFF0);
    check("busy_still_busy", {31'd0, busy}, 32'd1);
    wait_done(n_cyc, n_busy_low);
    check("busy_result_lo", lo, 32'd30);
    check("busy_result_hi", hi, 32'd0);
    @(negedge clock);
    check("busy_no_relaunch", {31'd0, busy}, 32'd0);

    // MTLO in IDLE writes on the next edge and leaves HI alone.
    we_lo = 1'b1;
    wd    = 32'hCAFE_F00D;
    @(negedge clock);
    we_lo = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_hi_kept", hi, 32'd0);

    // Back-to-back: a start taken in DONE launches the next operation.
    launch(MULTU, 32'd4, 32'd4);
    wait_done(n_cyc, n_busy_low);
    check("b2b_first_lo", lo, 32'd16);
    start = 1'b1;
    op    = MULTU;
    a     = 32'd3;
    b     = 32'd3;
    @(negedge clock);
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n_cyc, n_busy_low);
    check("b2b_latency", n_cyc, 32'd34);
    check("b2b_lo", lo, 32'd9);
    check("b2b_hi", hi, 32'd0);

    // Start and MTLO on the same edge: the write lands, then the result wins.
    @(negedge clock);
    start = 1'b1;
    op    = MULTU;
    a     = 32'd6;
    b     = 32'd7;
    we_lo = 1'b1;
    wd    = 32'h1111_1111;
    @(negedge clock);
    start = 1'b0;
    we_lo = 1'b0;
    check("same_edge_lo_written", lo, 32'h1111_1111);
    check("same_edge_busy", {31'd0, busy}, 32'd1);
    wait_done(n_cyc, n_busy_low);
    check("same_edge_result_lo", lo, 32'd42);

    // Reset asserted in cycle 10 of a MULTU clears everything at once.
    launch(MULTU, 32'd7, 32'd9);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clock);
    check("midrst_hold_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    launch(MULTU, 32'd7, 32'd9);
    wait_done(n_cyc, n_busy_low);
    check("postrst_latency", n_cyc, 32'd34);
    check("postrst_lo", lo, 32'h0000_003F);
    check("postrst_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
